// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide, with valid/ready on both sides.
module alu_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);
  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(W);
  localparam int CW  = $clog2(W + 1);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(3);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'(4);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTU  = OPCODE_LENGTH'(5);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(6);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = OPCODE_LENGTH'(7);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = OPCODE_LENGTH'(8);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = OPCODE_LENGTH'(9);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = OPCODE_LENGTH'(10);
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = OPCODE_LENGTH'(11);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = OPCODE_LENGTH'(12);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = OPCODE_LENGTH'(13);
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = OPCODE_LENGTH'(14);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                   state_reg, state_next;
  logic [OPCODE_LENGTH-1:0] op_reg, op_next;
  logic [W-1:0]             a_reg, a_next, b_reg, b_next;
  logic [W-1:0]             result_reg, result_next;
  logic [2*W-1:0]           prod_reg, prod_next;
  logic [CW-1:0]            count_reg, count_next;

  logic [W-1:0]   single_res;
  logic [SHW-1:0] shamt;
  logic           in_is_iter, in_is_mul, op_is_mul;
  logic [W:0]     mul_sum, div_shift;
  logic [W-1:0]   div_diff;
  logic           div_ge;
  logic [2*W-1:0] step;

  always_comb begin
    shamt      = SrcB[SHW-1:0];
    single_res = '0;
    case (Operation)
      OP_AND:  single_res = SrcA & SrcB;
      OP_OR:   single_res = SrcA | SrcB;
      OP_ADD:  single_res = SrcA + SrcB;
      OP_XOR:  single_res = SrcA ^ SrcB;
      OP_SLT:  single_res[0] = $signed(SrcA) < $signed(SrcB);
      OP_SLTU: single_res[0] = SrcA < SrcB;
      OP_SUB:  single_res = SrcA - SrcB;
      OP_SLL:  single_res = SrcA << shamt;
      OP_EQ:   single_res[0] = SrcA == SrcB;
      OP_SRL:  single_res = SrcA >> shamt;
      OP_SRA:  single_res = $unsigned($signed(SrcA) >>> shamt);
      default: single_res = '0;
    endcase
  end

  assign in_is_iter = (Operation == OP_MUL) || (Operation == OP_MULHU) ||
                      (Operation == OP_DIVU) || (Operation == OP_REMU);
  assign in_is_mul  = (Operation == OP_MUL) || (Operation == OP_MULHU);
  assign op_is_mul  = (op_reg == OP_MUL) || (op_reg == OP_MULHU);

  // prod_reg holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, prod_reg[2*W-1:W]} +
                (prod_reg[0] ? {1'b0, a_reg} : {(W + 1){1'b0}});
    div_shift = prod_reg[2*W-1:W-1];
    div_ge    = div_shift >= {1'b0, b_reg};
    div_diff  = div_shift[W-1:0] - b_reg;
    if (op_is_mul)
      step = {mul_sum, prod_reg[W-1:1]};
    else
      step = {(div_ge ? div_diff : div_shift[W-1:0]), prod_reg[W-2:0], div_ge};
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    prod_next   = prod_reg;
    count_next  = count_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next = Operation;
          a_next  = SrcA;
          b_next  = SrcB;
          if (in_is_iter) begin
            count_next = CW'(W);
            prod_next  = in_is_mul ? {{W{1'b0}}, SrcB} : {{W{1'b0}}, SrcA};
            state_next = CALC;
          end else begin
            result_next = single_res;
            state_next  = DONE;
          end
        end
      end
      CALC: begin
        prod_next  = step;
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          // MUL/DIVU take the low half, MULHU/REMU the high half.
          if (op_reg == OP_MUL || op_reg == OP_DIVU)
            result_next = step[W-1:0];
          else
            result_next = step[2*W-1:W];
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      prod_reg   <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      prod_reg   <= prod_next;
      count_reg  <= count_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == CALC);
  assign ALUResult = result_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases then random ops against an
// arithmetic reference model, with handshake timing and backpressure checks.
module tb_alu_seq;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  alu_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return a - b;
      4'd7:  return a << b[4:0];
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return a >> b[4:0];
      4'd10: return $unsigned($signed(a) >>> b[4:0]);
      4'd11: return p[31:0];
      4'd12: return p[63:32];
      4'd13: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One transaction: issue, wait (bounded) for the result, optionally stall the
  // consumer while a second request is held on the input, then retire.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, input bit hold_in);
    logic [31:0] exp;
    bit          iter;
    int          lat;
    int          busy_n;
    exp  = model(op, a, b);
    iter = (op >= 4'd11) && (op <= 4'd14);
    @(negedge clk);
    chk1("in_ready_idle", in_ready, 1'b1);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom;
    lat = 1; busy_n = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      chk1("in_ready_calc", in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, iter ? 32'd33 : 32'd1);
    chk("busy_cycles", busy_n, iter ? 32'd32 : 32'd0);
    chk("result", ALUResult, exp);
    chk1("busy_done", busy, 1'b0);
    for (int i = 0; i < stall; i++) begin
      if (hold_in) begin
        in_valid = 1'b1; Operation = 4'd2; SrcA = 32'd1; SrcB = 32'd1;
      end
      @(negedge clk);
      chk1("stall_out_valid", out_valid, 1'b1);
      chk1("stall_in_ready", in_ready, 1'b0);
      chk("stall_result", ALUResult, exp);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("retire_out_valid", out_valid, 1'b0);
    chk1("retire_in_ready", in_ready, 1'b1);
    $display("op=%h a=%h b=%h expected=%h got=%h latency=%0d stall=%0d",
             op, a, b, exp, ALUResult, lat, stall);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b1);
    chk("reset_result", ALUResult, 32'd0);

    do_op(4'd2,  32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(4'd11, 32'h8000_0000, 32'd4, 0, 1'b0);
    do_op(4'd12, 32'h8000_0000, 32'd4, 0, 1'b0);
    do_op(4'd13, 32'd100, 32'd7, 0, 1'b0);
    do_op(4'd14, 32'd100, 32'd7, 0, 1'b0);
    do_op(4'd13, 32'd5, 32'd0, 0, 1'b0);
    do_op(4'd14, 32'd5, 32'd0, 0, 1'b0);
    do_op(4'd6,  32'd3, 32'd5, 10, 1'b1);
    do_op(4'd10, 32'h8000_0000, 32'h21, 0, 1'b0);
    do_op(4'd4,  32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(4'd5,  32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
    do_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1);

    // Reset during an in-flight divide.
    @(negedge clk);
    Operation = 4'd13; SrcA = 32'd100; SrcB = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk1("midcalc_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("midreset_out_valid", out_valid, 1'b0);
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_in_ready", in_ready, 1'b1);
    chk("midreset_result", ALUResult, 32'd0);
    do_op(4'd8, 32'd7, 32'd7, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      do_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
